mem_port_arbiter: RTL and testbench

//  Shares one external memory port between the ifetch instruction port and the exe load/store port.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between ifetch and load/store; data wins unless ifetch has starved.
// Optional MEM_ARB_PERF_CNT_EN adds conflict/forced-grant counters.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [31:0]     if_rdata_o,
  input  logic            dm_req_i,
  input  logic [XLEN-1:0] dm_adr_i,
  input  logic            dm_we_i,
  input  logic [XLEN-1:0] dm_wdata_i,
  input  logic [2:0]      dm_size_i,
  output logic            dm_gnt_o,
  output logic            dm_rvalid_o,
  output logic [XLEN-1:0] dm_rdata_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]     conflict_cnt_o,
  output logic [31:0]     force_cnt_o
`endif
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_DM     = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic       lock_q, lock_d;
  logic       owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       present;
  logic       sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lock_q   <= 1'b0;
      owner_q  <= OWN_IF;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    present     = 1'b0;
    sel         = OWN_IF;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_gnt_o    = 1'b0;
    dm_rvalid_o = 1'b0;
    dm_rdata_o  = '0;
    mem_req_o   = 1'b0;
    mem_adr_o   = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_size_o  = 3'b000;
    // Outputs are forced quiet while reset is held, even though they are partly combinational.
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (lock_q) begin
            present = 1'b1;
            sel     = owner_q;
          end else begin
            present = if_req_i || dm_req_i;
            sel     = (dm_req_i && !(if_req_i && starve_q == STARVE_LIM)) ? OWN_DM : OWN_IF;
          end
          mem_req_o = present;
          if (present) begin
            if (sel == OWN_DM) begin
              mem_adr_o   = dm_adr_i;
              mem_we_o    = dm_we_i;
              mem_wdata_o = dm_wdata_i;
              mem_size_o  = dm_size_i;
            end else begin
              mem_adr_o   = if_adr_i;
              mem_size_o  = 3'b010;
            end
            owner_d = sel;
            if (mem_gnt_i) begin
              lock_d  = 1'b0;
              state_d = WAIT_RSP;
              if (sel == OWN_DM) begin
                dm_gnt_o = 1'b1;
                if (if_req_i && starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
              end else begin
                if_gnt_o = 1'b1;
                starve_d = 4'd0;
              end
            end else begin
              lock_d = 1'b1;
            end
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state_d = IDLE;
            if (owner_q == OWN_DM) begin
              dm_rvalid_o = 1'b1;
              dm_rdata_o  = mem_rdata_i;
            end else begin
              if_rvalid_o = 1'b1;
              if_rdata_o  = mem_rdata_i[31:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] conflict_q;
  logic [31:0] force_q;

  // An IF grant while the counter sits at its limit can only be a forced one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q <= 32'd0;
      force_q    <= 32'd0;
    end else begin
      if (state_q == IDLE && if_req_i && dm_req_i) conflict_q <= conflict_q + 32'd1;
      if (if_gnt_o && starve_q == STARVE_LIM) force_q <= force_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_q;
  assign force_cnt_o    = force_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            if_req_i = 1'b0;
  logic [XLEN-1:0] if_adr_i = '0;
  logic            if_gnt_o, if_rvalid_o;
  logic [31:0]     if_rdata_o;
  logic            dm_req_i = 1'b0;
  logic [XLEN-1:0] dm_adr_i = '0;
  logic            dm_we_i = 1'b0;
  logic [XLEN-1:0] dm_wdata_i = '0;
  logic [2:0]      dm_size_i = 3'b000;
  logic            dm_gnt_o, dm_rvalid_o;
  logic [XLEN-1:0] dm_rdata_o;
  logic            mem_req_o, mem_we_o;
  logic [XLEN-1:0] mem_adr_o, mem_wdata_o;
  logic [2:0]      mem_size_o;
  logic            mem_gnt_i = 1'b0;
  logic            mem_rvalid_i = 1'b0;
  logic [XLEN-1:0] mem_rdata_i = '0;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]     conflict_cnt_o, force_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_adr_i(dm_adr_i), .dm_we_i(dm_we_i),
    .dm_wdata_i(dm_wdata_i), .dm_size_i(dm_size_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef MEM_ARB_PERF_CNT_EN
    , .conflict_cnt_o(conflict_cnt_o), .force_cnt_o(force_cnt_o)
`endif
  );

  task automatic clear_inputs();
    if_req_i = 1'b0; if_adr_i = '0;
    dm_req_i = 1'b0; dm_adr_i = '0; dm_we_i = 1'b0; dm_wdata_i = '0; dm_size_i = 3'b000;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    if_req_i = 1'b1; if_adr_i = 32'h44; dm_req_i = 1'b1; dm_adr_i = 32'h88; dm_we_i = 1'b1;
    dm_wdata_i = 32'hFFFF_FFFF; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({mem_req_o, mem_we_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {mem_req_o, mem_we_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o});
    end
    n_checks++;
    if ({mem_adr_o, mem_wdata_o, mem_size_o, if_rdata_o, dm_rdata_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: adr=%h wdata=%h size=%b ird=%h drd=%h want all 0", mem_adr_o, mem_wdata_o, mem_size_o, if_rdata_o, dm_rdata_o);
    end
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_req: got %b want 0", mem_req_o); end
  endtask

  task automatic test_lone_if();
    @(negedge clk);
    if_req_i = 1'b1; if_adr_i = 32'h80; mem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o} !== {1'b1, 32'h80, 1'b0, 32'h0, 3'b010}) begin
      n_fail++; $display("FAIL lone_present: req=%b adr=%h we=%b wd=%h sz=%b want 1 80 0 0 010", mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o);
    end
    n_checks++;
    if ({if_gnt_o, dm_gnt_o} !== 2'b10) begin n_fail++; $display("FAIL lone_gnt: got %b want 10", {if_gnt_o, dm_gnt_o}); end
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0;
    #1;
    n_checks++;
    if ({mem_req_o, if_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL lone_wait: got %b want 00", {mem_req_o, if_rvalid_o}); end
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    #1;
    n_checks++;
    if ({if_rvalid_o, if_rdata_o, dm_rvalid_o, dm_rdata_o} !== {1'b1, 32'h13, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL lone_rsp: irv=%b ird=%h drv=%b drd=%h want 1 13 0 0", if_rvalid_o, if_rdata_o, dm_rvalid_o, dm_rdata_o);
    end
    @(negedge clk);
    mem_rdata_i = 32'h1234;
    #1;
    n_checks++;
    if ({if_rvalid_o, dm_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL idle_rvalid_ignored: got %b want 00", {if_rvalid_o, dm_rvalid_o}); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_priority();
    @(negedge clk);
    if_req_i = 1'b1; if_adr_i = 32'h180;
    dm_req_i = 1'b1; dm_adr_i = 32'h100; dm_we_i = 1'b1; dm_wdata_i = 32'hDEAD_BEEF; dm_size_i = 3'b010;
    mem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if ({mem_adr_o, mem_we_o, mem_wdata_o, dm_gnt_o, if_gnt_o} !== {32'h100, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL prio_dm_first: adr=%h we=%b wd=%h dg=%b ig=%b want 100 1 deadbeef 1 0", mem_adr_o, mem_we_o, mem_wdata_o, dm_gnt_o, if_gnt_o);
    end
    @(negedge clk);
    dm_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    #1;
    n_checks++;
    if ({mem_req_o, if_gnt_o, dm_gnt_o, dm_rvalid_o, if_rvalid_o} !== 5'b00010) begin
      n_fail++; $display("FAIL prio_wait_rsp: got %b want 00010", {mem_req_o, if_gnt_o, dm_gnt_o, dm_rvalid_o, if_rvalid_o});
    end
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if ({if_gnt_o, mem_adr_o, mem_we_o, mem_wdata_o} !== {1'b1, 32'h180, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL prio_if_after: ig=%b adr=%h we=%b wd=%h want 1 180 0 0", if_gnt_o, mem_adr_o, mem_we_o, mem_wdata_o);
    end
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    #1;
    n_checks++;
    if ({if_rvalid_o, if_rdata_o, dm_rvalid_o} !== {1'b1, 32'h55, 1'b0}) begin
      n_fail++; $display("FAIL prio_if_rsp: irv=%b ird=%h drv=%b want 1 55 0", if_rvalid_o, if_rdata_o, dm_rvalid_o);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_lock();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if_req_i = 1'b1; if_adr_i = 32'h200;
      if (c >= 1) begin dm_req_i = 1'b1; dm_adr_i = 32'h300; dm_we_i = 1'b1; dm_wdata_i = 32'hA5A5; dm_size_i = 3'b001; end
      mem_gnt_i = (c == 3);
      #1;
      n_checks++;
      if ({mem_req_o, mem_adr_o, mem_we_o, mem_size_o, dm_gnt_o, if_gnt_o} !== {1'b1, 32'h200, 1'b0, 3'b010, 1'b0, (c == 3)}) begin
        n_fail++; $display("FAIL lock_c%0d: req=%b adr=%h we=%b sz=%b dg=%b ig=%b want 1 200 0 010 0 %0d", c, mem_req_o, mem_adr_o, mem_we_o, mem_size_o, dm_gnt_o, if_gnt_o, (c == 3));
      end
    end
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
    #1;
    n_checks++;
    if ({if_rvalid_o, dm_rvalid_o} !== 2'b10) begin n_fail++; $display("FAIL lock_if_rsp: got %b want 10", {if_rvalid_o, dm_rvalid_o}); end
    @(negedge clk);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if ({dm_gnt_o, mem_adr_o, mem_wdata_o, mem_size_o} !== {1'b1, 32'h300, 32'hA5A5, 3'b001}) begin
      n_fail++; $display("FAIL lock_dm_next: dg=%b adr=%h wd=%h sz=%b want 1 300 a5a5 001", dm_gnt_o, mem_adr_o, mem_wdata_o, mem_size_o);
    end
    @(negedge clk);
    dm_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
    #1;
    n_checks++;
    if ({dm_rvalid_o, dm_rdata_o, if_rvalid_o, if_rdata_o} !== {1'b1, 32'h99, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL lock_dm_rsp: drv=%b drd=%h irv=%b ird=%h want 1 99 0 0", dm_rvalid_o, dm_rdata_o, if_rvalid_o, if_rdata_o);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Both requesters saturate the port; expected winners follow the starvation rule directly.
  task automatic contend(input int n_txn, input string tag);
    int since_if;
    bit exp_dm;
    since_if = 0;
    for (int t = 0; t < n_txn; t++) begin
      @(negedge clk);
      if_req_i = 1'b1; if_adr_i = 32'h400; dm_req_i = 1'b1; dm_adr_i = 32'h500; dm_we_i = 1'b0;
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
      #1;
      exp_dm = (since_if < STARVE_MAX);
      n_checks++;
      if ({if_gnt_o, dm_gnt_o} !== {!exp_dm, exp_dm}) begin
        n_fail++; $display("FAIL %s_gnt_t%0d: got ig/dg=%b want %b", tag, t, {if_gnt_o, dm_gnt_o}, {!exp_dm, exp_dm});
      end
      since_if = exp_dm ? since_if + 1 : 0;
      @(negedge clk);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'(t) + 32'h1000;
      #1;
      n_checks++;
      if ({if_rvalid_o, dm_rvalid_o} !== {!exp_dm, exp_dm}) begin
        n_fail++; $display("FAIL %s_rsp_t%0d: got irv/drv=%b want %b", tag, t, {if_rvalid_o, dm_rvalid_o}, {!exp_dm, exp_dm});
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_starvation();
    contend(6, "starve");
  endtask

`ifdef MEM_ARB_PERF_CNT_EN
  task automatic test_perf_counters();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({conflict_cnt_o, force_cnt_o} !== 64'd0) begin
      n_fail++; $display("FAIL perf_reset: conflict=%0d force=%0d want 0 0", conflict_cnt_o, force_cnt_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    contend(10 * (STARVE_MAX + 1), "perf");
    #1;
    n_checks++;
    if (force_cnt_o !== 32'd10) begin n_fail++; $display("FAIL perf_force: got %0d want 10", force_cnt_o); end
    n_checks++;
    if (conflict_cnt_o !== 32'(10 * (STARVE_MAX + 1))) begin
      n_fail++; $display("FAIL perf_conflict: got %0d want %0d", conflict_cnt_o, 10 * (STARVE_MAX + 1));
    end
  endtask
`endif

  task automatic test_reset_mid_txn();
    @(negedge clk);
    if_req_i = 1'b1; if_adr_i = 32'h600; mem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 1", if_gnt_o); end
    @(negedge clk);
    reset_n = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
    #1;
    n_checks++;
    if ({mem_req_o, if_gnt_o, if_rvalid_o, if_rdata_o, mem_adr_o, mem_size_o} !== '0) begin
      n_fail++; $display("FAIL rstmid_quiet: req=%b ig=%b irv=%b ird=%h adr=%h sz=%b want all 0", mem_req_o, if_gnt_o, if_rvalid_o, if_rdata_o, mem_adr_o, mem_size_o);
    end
    @(negedge clk);
    reset_n = 1'b1; if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_o, if_rvalid_o, dm_rvalid_o} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_late_rvalid: got %b want 000", {mem_req_o, if_rvalid_o, dm_rvalid_o});
    end
    @(negedge clk);
    if_req_i = 1'b1; if_adr_i = 32'h700; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if ({if_gnt_o, mem_adr_o} !== {1'b1, 32'h700}) begin
      n_fail++; $display("FAIL rstmid_idle: ig=%b adr=%h want 1 700", if_gnt_o, mem_adr_o);
    end
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13;
    #1;
    n_checks++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h13}) begin
      n_fail++; $display("FAIL rstmid_rsp: irv=%b ird=%h want 1 13", if_rvalid_o, if_rdata_o);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Transaction-level model: pending requests, a committed choice once the port stalls,
  // an outstanding-response flag and the count of data wins over a waiting ifetch.
  task automatic test_random_traffic();
    bit          if_p = 0, dm_p = 0, busy = 0, committed = 0, commit_dm = 0, rsp_dm = 0;
    bit          pres, pick_dm;
    int          starved = 0;
    logic [31:0] if_a = '0, dm_a = '0, dm_wd = '0, exp_adr, exp_wd;
    logic        dm_w = 1'b0, exp_we;
    logic [2:0]  dm_s = 3'b000, exp_sz;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!if_p && $urandom_range(0, 2) == 0) begin if_p = 1; if_a = $urandom & 32'hFFFF_FFFC; end
      if (!dm_p && $urandom_range(0, 2) == 0) begin
        dm_p = 1; dm_a = $urandom; dm_wd = $urandom; dm_w = 1'($urandom_range(0, 1)); dm_s = 3'($urandom_range(0, 2));
      end
      if_req_i = if_p; if_adr_i = if_a;
      dm_req_i = dm_p; dm_adr_i = dm_a; dm_we_i = dm_w; dm_wdata_i = dm_wd; dm_size_i = dm_s;
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      mem_rdata_i = $urandom;
      #1;
      if (!busy) begin
        pres    = committed || if_p || dm_p;
        pick_dm = committed ? commit_dm : (dm_p && !(if_p && starved == STARVE_MAX));
        exp_adr = !pres ? 32'h0 : (pick_dm ? dm_a : if_a);
        exp_we  = pres && pick_dm && dm_w;
        exp_wd  = (pres && pick_dm) ? dm_wd : 32'h0;
        exp_sz  = !pres ? 3'b000 : (pick_dm ? dm_s : 3'b010);
        n_checks++;
        if ({mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o} !== {pres, exp_adr, exp_we, exp_wd, exp_sz}) begin
          n_fail++; $display("FAIL rnd_present c%0d: req=%b adr=%h we=%b wd=%h sz=%b want %b %h %b %h %b", c, mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o, pres, exp_adr, exp_we, exp_wd, exp_sz);
        end
        n_checks++;
        if ({if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o} !== {pres && mem_gnt_i && !pick_dm, pres && mem_gnt_i && pick_dm, 2'b00}) begin
          n_fail++; $display("FAIL rnd_idle_hs c%0d: ig/dg/irv/drv=%b want %b", c, {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}, {pres && mem_gnt_i && !pick_dm, pres && mem_gnt_i && pick_dm, 2'b00});
        end
        if (pres && mem_gnt_i) begin
          busy = 1; rsp_dm = pick_dm; committed = 0;
          if (pick_dm) begin
            if (if_p && starved < STARVE_MAX) starved++;
            dm_p = 0;
          end else begin
            starved = 0; if_p = 0;
          end
        end else if (pres) begin
          committed = 1; commit_dm = pick_dm;
        end
      end else begin
        n_checks++;
        if ({mem_req_o, if_gnt_o, dm_gnt_o} !== 3'b000) begin
          n_fail++; $display("FAIL rnd_wait_quiet c%0d: req/ig/dg=%b want 000", c, {mem_req_o, if_gnt_o, dm_gnt_o});
        end
        n_checks++;
        if ({if_rvalid_o, dm_rvalid_o, if_rdata_o, dm_rdata_o} !==
            {mem_rvalid_i && !rsp_dm, mem_rvalid_i && rsp_dm,
             (mem_rvalid_i && !rsp_dm) ? mem_rdata_i : 32'h0, (mem_rvalid_i && rsp_dm) ? mem_rdata_i : 32'h0}) begin
          n_fail++; $display("FAIL rnd_rsp c%0d: irv=%b drv=%b ird=%h drd=%h rvalid=%b to_dm=%b rdata=%h", c, if_rvalid_o, dm_rvalid_o, if_rdata_o, dm_rdata_o, mem_rvalid_i, rsp_dm, mem_rdata_i);
        end
        if (mem_rvalid_i) busy = 0;
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_if();
    test_priority();
    test_lock();
    test_starvation();
`ifdef MEM_ARB_PERF_CNT_EN
    test_perf_counters();
`endif
    test_reset_mid_txn();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
